// File: rtl/pong_pkg.sv
// Shared pong display types: field widths, default background colour and
// the box arbiter state encoding. No ports.
package pong_pkg;

  localparam int         COORD_W  = 9;
  localparam int         COLOR_W  = 3;
  localparam logic [2:0] BG_COLOR = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW
  } state_t;

endpackage

// File: rtl/box_draw_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker, searches from last+1 with wrap.
// Ports: req (requests), last (previous winner) -> grant (onehot), index, any.
module rr_grant #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [LW-1:0] index,
  output logic          any
);

  always_comb begin
    int          j;
    logic [LW-1:0] jl;
    grant = '0;
    index = '0;
    any   = 1'b0;
    j     = 0;
    jl    = '0;
    for (int k = 1; k <= N; k++) begin
      j  = (int'(last) + k) % N;
      jl = LW'(j);
      if (!any && req[jl]) begin
        any       = 1'b1;
        grant[jl] = 1'b1;
        index     = jl;
      end
    end
  end

endmodule

// File: rtl/box_draw_arbiter.sv
// Round-robin arbiter sharing the box drawer; optional erase of the previous
// box via `BOX_ERASE_EN. Ports: clock, reset_n, in_* requesters, m_*/out_* drawer, busy.
module box_draw_arbiter
  import pong_pkg::*;
#(
  parameter int                 NUM_REQ  = 4,
  parameter int                 COORD_W  = pong_pkg::COORD_W,
  parameter int                 COLOR_W  = pong_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR = pong_pkg::BG_COLOR
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           in_valid,
  output logic [NUM_REQ-1:0]           in_ready,
  input  logic [NUM_REQ*COORD_W-1:0]   in_box_x,
  input  logic [NUM_REQ*COORD_W-1:0]   in_box_y,
  input  logic [NUM_REQ*COORD_W-1:0]   in_box_w,
  input  logic [NUM_REQ*COORD_W-1:0]   in_box_h,
  input  logic [NUM_REQ*COLOR_W-1:0]   in_box_color,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [COORD_W-1:0]           out_box_x,
  output logic [COORD_W-1:0]           out_box_y,
  output logic [COORD_W-1:0]           out_box_w,
  output logic [COORD_W-1:0]           out_box_h,
  output logic [COLOR_W-1:0]           out_box_color,
  output logic                         busy
);

  localparam int LW = $clog2(NUM_REQ);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [COLOR_W-1:0] c;
  } box_t;

  state_t              state;
  box_t                out_q;
  box_t                req_box [NUM_REQ];
  logic [LW-1:0]       last_grant;
  logic [LW-1:0]       g_q;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [LW-1:0]       pick_idx;
  logic                pick_any;

`ifdef BOX_ERASE_EN
  box_t                cur_q;
  box_t                prev_q [NUM_REQ];
  logic [NUM_REQ-1:0]  has_prev;
`else
  logic                unused_bg;
  assign unused_bg = ^BG_COLOR;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_box[i] = {
      in_box_x[i*COORD_W +: COORD_W],
      in_box_y[i*COORD_W +: COORD_W],
      in_box_w[i*COORD_W +: COORD_W],
      in_box_h[i*COORD_W +: COORD_W],
      in_box_color[i*COLOR_W +: COLOR_W]
    };
  end

  rr_grant #(
    .N  (NUM_REQ),
    .LW (LW)
  ) u_rr (
    .req   (in_valid),
    .last  (last_grant),
    .grant (pick_oh),
    .index (pick_idx),
    .any   (pick_any)
  );

  // Transfer happens in the grant cycle, so ready is combinational.
  assign in_ready = (state == IDLE) ? pick_oh : '0;
  assign busy     = (state != IDLE);

  assign out_box_x     = out_q.x;
  assign out_box_y     = out_q.y;
  assign out_box_w     = out_q.w;
  assign out_box_h     = out_q.h;
  assign out_box_color = out_q.c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      m_valid    <= 1'b0;
      out_q      <= '0;
      last_grant <= LW'(NUM_REQ - 1);
      g_q        <= '0;
`ifdef BOX_ERASE_EN
      cur_q      <= '0;
      has_prev   <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        prev_q[i] <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            g_q     <= pick_idx;
            m_valid <= 1'b1;
`ifdef BOX_ERASE_EN
            cur_q <= req_box[pick_idx];
            if (has_prev[pick_idx]) begin
              state <= ERASE;
              out_q <= {prev_q[pick_idx].x,
                        prev_q[pick_idx].y,
                        prev_q[pick_idx].w,
                        prev_q[pick_idx].h,
                        BG_COLOR};
            end else begin
              state <= DRAW;
              out_q <= req_box[pick_idx];
            end
`else
            state <= DRAW;
            out_q <= req_box[pick_idx];
`endif
          end
        end
        ERASE: begin
`ifdef BOX_ERASE_EN
          if (m_ready) begin
            state <= DRAW;
            out_q <= cur_q;
          end
`else
          state   <= IDLE;
          m_valid <= 1'b0;
`endif
        end
        DRAW: begin
          if (m_ready) begin
            state      <= IDLE;
            m_valid    <= 1'b0;
            last_grant <= g_q;
`ifdef BOX_ERASE_EN
            prev_q[g_q]   <= cur_q;
            has_prev[g_q] <= 1'b1;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
